// File: rtl/vga_hl_pkg.sv
// Shared constants for the VGA field-highlight overlay.
// The pointer-code table, the "no field" code, the FSM state codes and the default colours.
package vga_hl_pkg;

  localparam int MAX_FIELDS = 9;

  localparam logic [3:0] NONE_FIELD = 4'hF;

  // Keyboard/control path cursor codes, indexed by field number.
  localparam logic [7:0] PTR_CODE [MAX_FIELDS] = '{
    8'h24, 8'h25, 8'h26, 8'h23, 8'h22, 8'h21, 8'h43, 8'h42, 8'h41
  };

  localparam logic [1:0] S_NONE = 2'd0;
  localparam logic [1:0] S_SHOW = 2'd1;
  localparam logic [1:0] S_HIDE = 2'd2;

  localparam logic [11:0] DEF_BG_COLOR = 12'h000;
  localparam logic [11:0] DEF_HL_COLOR = 12'hFFF;

endpackage

// File: rtl/vga_field_highlight_blink.sv
// Frame-count blink phase generator for the highlight overlay (built only with HL_BLINK_EN).
// Phase 0 = highlight visible; each phase lasts BLINK_FRAMES frame edges.
`ifdef HL_BLINK_EN
module hl_blink_timer #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_edge,
  input  logic restart,
  output logic phase
);

  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      phase <= 1'b0;
    end else if (frame_edge) begin
      if (restart) begin
        count <= '0;
        phase <= 1'b0;
      end else if (count == CW'(BLINK_FRAMES - 1)) begin
        count <= '0;
        phase <= ~phase;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/vga_field_highlight.sv
// Cursor-highlight overlay between the character renderer and the VGA pins.
// Define HL_BLINK_EN to blink the highlight; otherwise the selected field is lit steadily.
module vga_field_highlight
  import vga_hl_pkg::*;
#(
  parameter int               NUM_FIELDS   = 9,
  parameter int               SEL_W        = 5,
  parameter int               PTR_W        = 8,
  parameter int               COLOR_W      = 12,
  parameter int               SEL_BASE     = 2,
  parameter logic [COLOR_W-1:0] BG_COLOR   = DEF_BG_COLOR,
  parameter logic [COLOR_W-1:0] HL_COLOR   = DEF_HL_COLOR,
  parameter int               BLINK_FRAMES = 30,
  parameter logic             SYNC_IDLE    = 1'b1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [PTR_W-1:0]   PUNTERO,
  input  logic [COLOR_W-1:0] COLOR_IN,
  input  logic [SEL_W-1:0]   SEL_IN,
  input  logic               HS_IN,
  input  logic               VS_IN,
  output logic [COLOR_W-1:0] COLOR_OUT,
  output logic               HS_OUT,
  output logic               VS_OUT,
  output logic [3:0]         FIELD_OUT,
  output logic [1:0]         STATE_DBG
);

  localparam int XW = SEL_W + 1;

  if (BLINK_FRAMES < 1) begin : g_bad_blink_frames
    $error("BLINK_FRAMES must be at least 1");
  end

  logic       prev_vs;
  logic       frame_edge;
  logic [3:0] dec_field;
  logic [3:0] cur_field;
  logic [1:0] active_q;   // S_NONE or S_SHOW; blink phase is folded in below
  logic [1:0] state;
  logic       phase;
  logic       hit;
  logic [XW-1:0] sel_lo;
  logic [XW-1:0] sel_x;

  always_comb begin
    dec_field = NONE_FIELD;
    for (int i = 0; i < MAX_FIELDS; i++) begin
      if (i < NUM_FIELDS && PUNTERO == PTR_W'(PTR_CODE[i])) dec_field = 4'(i);
    end
  end

  assign frame_edge = prev_vs & ~VS_IN;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prev_vs   <= SYNC_IDLE;
      cur_field <= NONE_FIELD;
      active_q  <= S_NONE;
    end else begin
      prev_vs <= VS_IN;
      if (frame_edge) begin
        cur_field <= dec_field;
        active_q  <= (dec_field == NONE_FIELD) ? S_NONE : S_SHOW;
      end
    end
  end

`ifdef HL_BLINK_EN
  logic restart;

  // Any pointer change (including to/from "none") restarts the visible phase.
  assign restart = (dec_field == NONE_FIELD) || (active_q == S_NONE) ||
                   (dec_field != cur_field);

  hl_blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk        (CLK),
    .rst        (RST),
    .frame_edge (frame_edge),
    .restart    (restart),
    .phase      (phase)
  );
`else
  assign phase = 1'b0;
`endif

  assign state = (active_q == S_SHOW && phase) ? S_HIDE : active_q;
  assign STATE_DBG = state;
  assign FIELD_OUT = cur_field;

  // Extra selector bit keeps base + 2*field from wrapping into low selector codes.
  assign sel_lo = XW'(SEL_BASE) + (XW'(cur_field) << 1);
  assign sel_x  = {1'b0, SEL_IN};
  assign hit    = (sel_x == sel_lo) || (sel_x == sel_lo + XW'(1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      COLOR_OUT <= '0;
      HS_OUT    <= SYNC_IDLE;
      VS_OUT    <= SYNC_IDLE;
    end else begin
      COLOR_OUT <= (state == S_SHOW && hit && COLOR_IN == BG_COLOR) ? HL_COLOR : COLOR_IN;
      HS_OUT    <= HS_IN;
      VS_OUT    <= VS_IN;
    end
  end

endmodule

// File: tb/tb_vga_field_highlight.sv
// Directed bench for vga_field_highlight with a per-pixel expected-output queue.
module tb_vga_field_highlight;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  PUNTERO;
  logic [11:0] COLOR_IN;
  logic [4:0]  SEL_IN;
  logic        HS_IN;
  logic        VS_IN;
  logic [11:0] COLOR_OUT;
  logic        HS_OUT;
  logic        VS_OUT;
  logic [3:0]  FIELD_OUT;
  logic [1:0]  STATE_DBG;

  int n_vec = 0;
  int n_err = 0;

  logic [13:0] exp_q[$];

  // Reference model state
  logic       m_prev_vs;
  logic [3:0] m_field;
  int         m_state;   // 0 none, 1 show, 2 hide
  int         m_cnt;

`ifdef HL_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif
  localparam int BF = 2;

  vga_field_highlight #(
    .BLINK_FRAMES(BF)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .PUNTERO   (PUNTERO),
    .COLOR_IN  (COLOR_IN),
    .SEL_IN    (SEL_IN),
    .HS_IN     (HS_IN),
    .VS_IN     (VS_IN),
    .COLOR_OUT (COLOR_OUT),
    .HS_OUT    (HS_OUT),
    .VS_OUT    (VS_OUT),
    .FIELD_OUT (FIELD_OUT),
    .STATE_DBG (STATE_DBG)
  );

  always #5 CLK = ~CLK;

  function automatic logic [3:0] decode(input logic [7:0] p);
    case (p)
      8'h24: return 4'd0;
      8'h25: return 4'd1;
      8'h26: return 4'd2;
      8'h23: return 4'd3;
      8'h22: return 4'd4;
      8'h21: return 4'd5;
      8'h43: return 4'd6;
      8'h42: return 4'd7;
      8'h41: return 4'd8;
      default: return 4'hF;
    endcase
  endfunction

  task automatic model_reset();
    m_prev_vs = 1'b1;
    m_field   = 4'hF;
    m_state   = 0;
    m_cnt     = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One pixel: drive, predict, then compare the registered output one clock later.
  task automatic pix(input logic [11:0] c, input logic [4:0] s, input logic hs, input logic vs);
    int          lo;
    logic        hit;
    logic [11:0] ec;
    logic [3:0]  d;
    logic [13:0] e;
    @(negedge CLK);
    COLOR_IN = c;
    SEL_IN   = s;
    HS_IN    = hs;
    VS_IN    = vs;
    lo  = 2 + 2 * int'(m_field);
    hit = (m_field != 4'hF) && (int'(s) == lo || int'(s) == lo + 1);
    ec  = (m_state == 1 && hit && c == 12'h000) ? 12'hFFF : c;
    exp_q.push_back({ec, hs, vs});
    if (m_prev_vs && !vs) begin
      d = decode(PUNTERO);
      if (d == 4'hF) begin
        m_state = 0; m_cnt = 0;
      end else if (m_state == 0 || d != m_field) begin
        m_state = 1; m_cnt = 0;
      end else if (BLINK) begin
        if (m_cnt == BF - 1) begin
          m_state = (m_state == 1) ? 2 : 1;
          m_cnt   = 0;
        end else begin
          m_cnt++;
        end
      end
      m_field = d;
    end
    m_prev_vs = vs;
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    check($sformatf("pix_sel%0d", s), 32'({COLOR_OUT, HS_OUT, VS_OUT}), 32'(e));
  endtask

  task automatic vsync();
    pix(12'($urandom_range(0, 4095)), 5'd0, 1'b1, 1'b1);
    pix(12'h000, 5'd0, 1'b1, 1'b0);
    pix(12'h000, 5'd0, 1'b0, 1'b0);
    pix(12'h000, 5'd0, 1'b1, 1'b1);
    check("field_out", 32'(FIELD_OUT), 32'(m_field));
    check("state_dbg", 32'(STATE_DBG), 32'(m_state));
  endtask

  task automatic line();
    for (int s = 0; s < 20; s++) begin
      pix(12'h000, 5'(s), 1'b1, 1'b1);
      pix(12'h0F0, 5'(s), 1'b1, 1'b1);
    end
    for (int k = 0; k < 6; k++)
      pix(12'($urandom_range(0, 4095)), 5'($urandom_range(0, 31)),
          1'($urandom_range(0, 1)), 1'b1);
  endtask

  task automatic reset_checks();
    check("rst_color", 32'(COLOR_OUT), 32'h0);
    check("rst_hs", 32'(HS_OUT), 32'h1);
    check("rst_vs", 32'(VS_OUT), 32'h1);
    check("rst_field", 32'(FIELD_OUT), 32'hF);
    check("rst_state", 32'(STATE_DBG), 32'h0);
  endtask

  task automatic mid_line_reset();
    @(negedge CLK);
    #2;
    RST = 1'b1;
    COLOR_IN = 12'hABC;
    HS_IN = 1'b0;
    #1;
    reset_checks();
    repeat (2) @(posedge CLK);
    #1;
    reset_checks();
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
  endtask

  initial begin
    RST = 1'b1; PUNTERO = 8'h00; COLOR_IN = 12'hABC; SEL_IN = '0; HS_IN = 1'b1; VS_IN = 1'b1;
    model_reset();
    #12;
    reset_checks();
    @(negedge CLK);
    RST = 1'b0;

    // Plain passthrough, then field 1 (selectors 4/5)
    line();
    PUNTERO = 8'h25;
    vsync();
    line();

    // Async reset mid-line: highlight only returns after the next frame edge
    pix(12'h000, 5'd4, 1'b1, 1'b1);
    mid_line_reset();
    line();
    vsync();
    line();

    // Last field, then an unknown code
    PUNTERO = 8'h41;
    vsync();
    line();
    PUNTERO = 8'h99;
    vsync();
    line();

    // Mid-frame pointer change is deferred to the next frame edge
    PUNTERO = 8'h24;
    vsync();
    pix(12'h000, 5'd2, 1'b1, 1'b1);
    PUNTERO = 8'h23;
    line();
    vsync();
    line();

    // Fixed pointer across many frames: steady or blinking depending on build
    repeat (10) begin
      vsync();
      pix(12'h000, 5'd8, 1'b1, 1'b1);
      pix(12'h000, 5'd9, 1'b1, 1'b1);
      pix(12'h000, 5'd10, 1'b1, 1'b1);
    end

    // Pointer change landing on what would be a blink-expiry edge
    PUNTERO = 8'h22;
    vsync();
    pix(12'h000, 5'd10, 1'b1, 1'b1);
    vsync();
    pix(12'h000, 5'd10, 1'b1, 1'b1);
    PUNTERO = 8'h21;
    vsync();
    pix(12'h000, 5'd12, 1'b1, 1'b1);
    repeat (5) begin
      vsync();
      pix(12'h000, 5'd12, 1'b1, 1'b1);
      pix(12'h000, 5'd13, 1'b1, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
